// File: rtl/seq_priority_encoder_pkg.sv
// Shared sizing, FSM state type and lowest-set-bit helper for the sequential priority encoder.
// Consumed by the interface, the index encoder and the top level.
package enc_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;

    // Two's-complement trick: vec & -vec keeps only the lowest set bit.
    function automatic logic [N-1:0] onehot_lsb(input logic [N-1:0] vec);
        return vec & (-vec);
    endfunction

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Request-vector input stream and index output stream of seq_priority_encoder.
// master = producer/consumer side, slave = the encoder.
interface seq_priority_encoder_if;
    import enc_pkg::*;

    logic         in_valid;
    logic [N-1:0] in_vec;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic         out_ready;
    logic         busy;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_last,
        output busy
    );

endinterface

// File: rtl/seq_priority_encoder_lsb.sv
// Combinational lowest-set-bit index encoder: o_idx is the smallest i with i_vec[i]=1, 0 when empty.
// o_any flags a non-empty vector.
module lsb_index_enc
    import enc_pkg::*;
#(
    parameter int VN = N,
    parameter int VW = W
) (
    input  logic [VN-1:0] i_vec,
    output logic [VW-1:0] o_idx,
    output logic          o_any
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = '0;
        for (int i = VN - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = VW'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/seq_priority_encoder.sv
// Registered 8-to-3 priority encoder: emits each set bit of a captured vector, lowest first, one per handshake.
// Build option ENC_MERGE_EN: OR-merge new vectors into pending and keep in_ready high.
module seq_priority_encoder
    import enc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    seq_priority_encoder_if.slave  bus
);

    logic [N-1:0] r_pending;
    logic [N-1:0] w_pending_nxt;
    logic [N-1:0] w_lsb_onehot;
    logic [N-1:0] w_consumed;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_accept;
    logic         w_consume;
    enc_state_t   r_state;
    enc_state_t   w_state_nxt;

    lsb_index_enc #(
        .VN (N),
        .VW (W)
    ) u_lsb_index_enc (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_lsb_onehot = onehot_lsb(r_pending);

`ifdef ENC_MERGE_EN
    assign bus.in_ready = 1'b1;
`else
    assign bus.in_ready = (r_state == IDLE);
`endif

    // Every output field comes from the registered pending vector only.
    assign bus.out_valid = w_any;
    assign bus.out_idx   = w_idx;
    assign bus.out_last  = w_any && (r_pending == w_lsb_onehot);
    assign bus.busy      = w_any;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_consume  = bus.out_valid && bus.out_ready;
    assign w_consumed = w_consume ? w_lsb_onehot : '0;

    always_comb begin
        w_pending_nxt = r_pending;
`ifdef ENC_MERGE_EN
        // A bit consumed and re-offered in the same cycle survives and is emitted again.
        w_pending_nxt = (r_pending & ~w_consumed) | (w_accept ? bus.in_vec : '0);
`else
        if (w_accept) begin
            w_pending_nxt = bus.in_vec;
        end else begin
            w_pending_nxt = r_pending & ~w_consumed;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pending_nxt != '0) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leaves only when the last pending bit goes out with nothing merged in behind it.
                if (w_pending_nxt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_state   <= IDLE;
        end else begin
            r_pending <= w_pending_nxt;
            r_state   <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed and randomized checks of seq_priority_encoder against a queue-of-indices reference model.
module tb_seq_priority_encoder;

`ifdef ENC_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   ncomp;
    int   nfail;

    logic [2:0] q[$];
    logic [2:0] got[$];

    seq_priority_encoder_if bus ();

    seq_priority_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncomp++;
        assert (obs === exp_v)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [2:0] e[$]);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            chk(tag, got[i], e[i]);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model past the next posedge.
    task automatic step(input logic v, input logic [7:0] vec, input logic rdy);
        logic       exp_rdy;
        logic       exp_vld;
        logic       acc;
        logic       con;
        logic [7:0] s;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_vec    = vec;
        bus.out_ready = rdy;
        #1;
        exp_rdy = MERGE ? 1'b1 : (q.size() == 0);
        exp_vld = (q.size() != 0);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, exp_vld);
        chk("busy", bus.busy, exp_vld);
        if (exp_vld) begin
            chk("out_idx", bus.out_idx, q[0]);
            chk("out_last", bus.out_last, q.size() == 1);
        end
        if (bus.out_valid && rdy) got.push_back(bus.out_idx);
        acc = v && exp_rdy;
        con = exp_vld && rdy;
        if (con) void'(q.pop_front());
        if (acc) begin
            s = vec;
            if (MERGE) foreach (q[i]) s[q[i]] = 1'b1;
            q.delete();
            for (int b = 0; b < 8; b++) if (s[b]) q.push_back(b[2:0]);
        end
    endtask

    initial begin
        ncomp = 0;
        nfail = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_idx", bus.out_idx, 3'd0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of draining 8'hA5.
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_out_idx", bus.out_idx, 3'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("midrst_no_emit", got.size(), 0);

        // 8'b1001_0110 drains as 1,2,4,7 back to back.
        got.delete();
        step(1'b1, 8'b1001_0110, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_seq("seq_96", '{3'd1, 3'd2, 3'd4, 3'd7});

        // Top bit held under backpressure.
        got.delete();
        step(1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("hold_idx7", bus.out_idx, 3'd7);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk_seq("seq_80", '{3'd7});

        got.delete();
`ifdef ENC_MERGE_EN
        // Consume and re-accept of bit 0 in the same cycle re-emits index 0.
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h01, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk_seq("seq_merge", '{3'd0, 3'd0});
`else
        // 8'h03 is back-pressured until 8'h30 has drained.
        step(1'b1, 8'h30, 1'b0);
        step(1'b1, 8'h03, 1'b1);
        chk("bp_in_ready", bus.in_ready, 1'b0);
        step(1'b1, 8'h03, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_seq("seq_bp", '{3'd4, 3'd5, 3'd0, 3'd1});
`endif

        // Zero vector is accepted and leaves the block idle.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("zero_out_valid", bus.out_valid, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
